mem_stage: RTL
==============

# mem_stage

Memory-access stage of the single-issue pipeline. It consumes the EXE/MEM pipeline register (ALU result, store data, destination, memory controls), performs loads and stores on the data-memory port with a request/acknowledge handshake, stalls upstream stages while an access is outstanding, and drives the MEM/WB pipeline register plus the MEM-stage forwarding taps used by EXE.

## Interface
- TIMEOUT, 16: cycles a request may remain unacknowledged before it is aborted (range 2..255).
- CLK  in  1  clock; all state updates on the rising edge.
- RESET  in  1  asynchronous, active-low reset.
- aluResult1_PR  in  32  effective address, or ALU result for non-memory instructions.
- readDataB1_PR  in  32  store data, unshifted.
- Instr1_PR  in  32  instruction; bits [31:26] select access width and sign.
- writeRegister1_PR  in  5  destination register.
- MemtoReg1_PR, MemRead1_PR, MemWrite1_PR, do_writeback1_PR  in  1 each  EXE/MEM control bits.
- dmem_rdata  in  32  read data, valid when dmem_ack is high.
- dmem_ack  in  1  access complete this cycle.
- dmem_req  out  1  access request.
- dmem_we  out  1  1 = write.
- dmem_addr  out  32  word-aligned address ({addr[31:2],2'b00}).
- dmem_wdata  out  32  lane-shifted store data.
- dmem_be  out  4  byte enables, bit i = byte lane i (little-endian).
- FREEZE  out  1  stall EXE and earlier stages.
- Data1_MEM, writeRegister1_MEM, do_writeback1_MEM  out  32/5/1  forwarding taps, combinational from inputs.
- load_in_MEM  out  1  MemRead1_PR && !MemWrite1_PR; hazard unit must not forward Data1_MEM for loads.
- Data1_WB, writeRegister1_WB, do_writeback1_WB  out  32/5/1  MEM/WB register.
- addr_error, bus_error  out  1 each  one-cycle registered error pulses.

## Operation
- Access decode from Instr1_PR[31:26]: 0x20 LB, 0x21 LH, 0x23 LW, 0x24 LBU, 0x25 LHU, 0x28 SB, 0x29 SH, 0x2B SW; any other opcode with a memory control bit set is treated as word.
- mem_op = MemRead1_PR || MemWrite1_PR. MemWrite1_PR has priority when both are set.
- Alignment: halfword requires addr[0]=0; word requires addr[1:0]=0. A misaligned op issues no request, does not stall, pulses addr_error, and writes a bubble to WB (do_writeback1_WB=0).
- Byte enables: byte 4'b0001<<addr[1:0]; half 4'b0011<<addr[1:0]; word 4'b1111; loads drive 4'b1111.
- Store data: byte/half replicated across lanes (wdata = {4{b}} / {2{h}}).
- Load data: lane selected by addr[1:0], then sign-extended (LB, LH) or zero-extended (LBU, LHU).
- Data1_WB = MemtoReg1_PR ? extended load data : aluResult1_PR. Data1_MEM = aluResult1_PR.
- FSM states IDLE and WAIT, plus an 8-bit wait counter.
  - IDLE: aligned mem_op with !dmem_ack -> WAIT, counter=1. With dmem_ack, the access completes in zero wait states and the FSM stays IDLE.
  - WAIT: dmem_ack -> IDLE (complete). counter==TIMEOUT-1 without ack -> IDLE, abort.
- Abort: bus_error pulses, dmem_req drops, and a WB bubble is written. The store is considered lost.
- dmem_req = aligned mem_op && !abort_this_cycle. It holds with address, data, and enables stable until ack or abort.
- FREEZE = dmem_req && !dmem_ack.

## Timing
- Reset: every output register is 0, FSM is IDLE, counter is 0. FREEZE, dmem_req, and dmem_* outputs are 0 because the inputs are cleared by upstream reset.
- Non-memory instruction: WB register loads on the next edge (latency 1).
- Zero-wait access (ack in the request cycle): no stall. WB loads at that edge.
- N-wait access: FREEZE is high for N cycles. WB receives a bubble on each frozen edge and the real result on the ack edge.
- Ack on the same edge the counter reaches TIMEOUT-1: ack wins, access completes normally.
- dmem_ack while dmem_req=0: ignored.
- Reset mid-access: FSM returns to IDLE immediately and the pending access is dropped. The memory must treat the deasserted req as a cancel.
- Error pulses are high for exactly one cycle, in the cycle after the detecting edge.

## Test plan
- ALU op (aluResult=0x0000_1234, dst=5, wb=1, MemtoReg=0) -> next cycle Data1_WB=0x1234, writeRegister1_WB=5, FREEZE never high.
- LB at 0x103, memory word 0x80FF_0000, ack after 3 waits -> FREEZE high 3 cycles, dmem_be=4'b1111, Data1_WB=0xFFFF_FF80, three WB bubbles precede the result.
- SH data 0x0000_ABCD to 0x202, zero-wait ack -> dmem_be=4'b1100, dmem_wdata=0xABCD_ABCD, dmem_addr=0x200, no stall.
- LW at 0x102 -> no dmem_req, addr_error one-cycle pulse, do_writeback1_WB=0.
- LW with dmem_ack held low, TIMEOUT=16 -> FREEZE high 15 cycles, bus_error pulse, WB bubble, FSM back to IDLE, next instruction proceeds.
- RESET asserted in WAIT after 2 wait cycles -> all outputs 0 immediately. After release, a fresh LW with zero-wait ack completes with no stall.

Source files
------------

// File: rtl/mem_stage.sv
// mem_stage: memory-access stage. Performs loads/stores over a req/ack data
// port, stalls upstream while an access is outstanding, aborts requests that
// stay unacknowledged too long, and drives the MEM/WB register and MEM taps.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | no access outstanding; a new access may complete at once
// S_WAIT | request issued, waiting for dmem_ack; r_cnt counts waits
module mem_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] aluResult1_PR,
  input  logic [31:0] readDataB1_PR,
  input  logic [31:0] Instr1_PR,
  input  logic [4:0]  writeRegister1_PR,
  input  logic        MemtoReg1_PR,
  input  logic        MemRead1_PR,
  input  logic        MemWrite1_PR,
  input  logic        do_writeback1_PR,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  output logic        FREEZE,
  output logic [31:0] Data1_MEM,
  output logic [4:0]  writeRegister1_MEM,
  output logic        do_writeback1_MEM,
  output logic        load_in_MEM,
  output logic [31:0] Data1_WB,
  output logic [4:0]  writeRegister1_WB,
  output logic        do_writeback1_WB,
  output logic        addr_error,
  output logic        bus_error
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  localparam logic [7:0] LP_LAST = 8'(TIMEOUT - 1);

  state_t      r_state, w_state_nxt;
  logic [7:0]  r_cnt, w_cnt_nxt;
  logic        r_addr_error, r_bus_error;
  logic [31:0] r_data_wb;
  logic [4:0]  r_reg_wb;
  logic        r_wb_wb;

  logic [5:0]  w_opc;
  logic [1:0]  w_off;
  logic        w_is_byte, w_is_half, w_is_unsigned;
  logic        w_mem_op, w_misaligned, w_misaligned_op, w_aligned_op;
  logic        w_abort, w_req;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_ext;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;

  assign w_opc         = Instr1_PR[31:26];
  assign w_off         = aluResult1_PR[1:0];
  assign w_is_byte     = (w_opc == 6'h20) || (w_opc == 6'h24) || (w_opc == 6'h28);
  assign w_is_half     = (w_opc == 6'h21) || (w_opc == 6'h25) || (w_opc == 6'h29);
  assign w_is_unsigned = (w_opc == 6'h24) || (w_opc == 6'h25);

  assign w_mem_op        = MemRead1_PR || MemWrite1_PR;
  assign w_misaligned    = w_is_half ? w_off[0] : (!w_is_byte && (w_off != 2'b00));
  assign w_misaligned_op = w_mem_op && w_misaligned;
  assign w_aligned_op    = w_mem_op && !w_misaligned;

  // An ack arriving on the last allowed wait cycle beats the abort.
  assign w_abort = (r_state == S_WAIT) && w_aligned_op && !dmem_ack && (r_cnt == LP_LAST);
  assign w_req   = w_aligned_op && !w_abort;

  assign w_byte = dmem_rdata[{w_off, 3'b000} +: 8];
  assign w_half = dmem_rdata[{w_off[1], 4'b0000} +: 16];

  // Access-width decode: load extension, store lane replication, byte enables.
  always_comb begin
    w_load_ext = dmem_rdata;
    w_wdata    = readDataB1_PR;
    w_be       = 4'b1111;
    if (w_is_byte) begin
      w_load_ext = w_is_unsigned ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
      w_wdata    = {4{readDataB1_PR[7:0]}};
      if (MemWrite1_PR) w_be = 4'b0001 << w_off;
    end else if (w_is_half) begin
      w_load_ext = w_is_unsigned ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
      w_wdata    = {2{readDataB1_PR[15:0]}};
      if (MemWrite1_PR) w_be = 4'b0011 << w_off;
    end
  end

  assign dmem_req   = w_req;
  assign dmem_we    = w_req && MemWrite1_PR;
  assign dmem_addr  = {aluResult1_PR[31:2], 2'b00};
  assign dmem_wdata = w_wdata;
  assign dmem_be    = w_req ? w_be : 4'b0000;
  assign FREEZE     = w_req && !dmem_ack;

  assign Data1_MEM          = aluResult1_PR;
  assign writeRegister1_MEM = writeRegister1_PR;
  assign do_writeback1_MEM  = do_writeback1_PR;
  assign load_in_MEM        = MemRead1_PR && !MemWrite1_PR;

  assign Data1_WB          = r_data_wb;
  assign writeRegister1_WB = r_reg_wb;
  assign do_writeback1_WB  = r_wb_wb;
  assign addr_error        = r_addr_error;
  assign bus_error         = r_bus_error;

  // FSM state and wait counter register.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state <= S_IDLE;
      r_cnt   <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state: enter WAIT on an unacknowledged request, leave on ack/abort.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_aligned_op && !dmem_ack) begin
          w_state_nxt = S_WAIT;
          w_cnt_nxt   = 8'd1;
        end
      end
      S_WAIT: begin
        if (!w_aligned_op || dmem_ack || w_abort) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = 8'd0;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = 8'd0;
      end
    endcase
  end

  // MEM/WB register: bubble while stalled, on abort and on misalignment.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_data_wb <= 32'd0;
      r_reg_wb  <= 5'd0;
      r_wb_wb   <= 1'b0;
    end else if (FREEZE || w_abort || w_misaligned_op) begin
      r_data_wb <= 32'd0;
      r_reg_wb  <= 5'd0;
      r_wb_wb   <= 1'b0;
    end else begin
      r_data_wb <= MemtoReg1_PR ? w_load_ext : aluResult1_PR;
      r_reg_wb  <= writeRegister1_PR;
      r_wb_wb   <= do_writeback1_PR;
    end
  end

  // One-cycle error pulses, registered from the detecting cycle.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_addr_error <= 1'b0;
      r_bus_error  <= 1'b0;
    end else begin
      r_addr_error <= w_misaligned_op;
      r_bus_error  <= w_abort;
    end
  end

endmodule
